// File: rtl/br_ctrl.sv
// Execute-stage branch resolution controller: evaluates one conditional branch at a time,
// redirects fetch on mispredict and maintains a 2-bit BHT plus branch statistics.
module br_ctrl #(
    parameter int unsigned DATAW = 32,
    parameter int unsigned IDXW  = 6,
    parameter int unsigned CNTW  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_type,
    input  logic [31:0]      req_pc,
    input  logic [31:0]      req_imm,
    input  logic             req_pred,
    input  logic             ops_valid,
    input  logic [DATAW-1:0] op_a,
    input  logic [DATAW-1:0] op_b,
    input  logic             kill,
    input  logic [31:0]      pred_pc,
    output logic             pred_taken,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNTW-1:0]  stat_branches,
    output logic [CNTW-1:0]  stat_mispred
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] EVAL  = 2'd1;
    localparam logic [1:0] REDIR = 2'd2;

    localparam int unsigned BhtN = 1 << IDXW;

    logic [1:0]      state_q, state_d;
    logic [2:0]      type_q;
    logic [31:0]     pc_q;
    logic [31:0]     imm_q;
    logic            pred_q;
    logic [31:0]     rpc_q, rpc_d;
    logic [1:0]      bht_q [BhtN];
    logic [1:0]      bht_d;
    logic [CNTW-1:0] br_cnt_q, br_cnt_d;
    logic [CNTW-1:0] mis_cnt_q, mis_cnt_d;

    logic            accept;
    logic            resolve;
    logic            taken;
    logic            legal;
    logic            mispred;
    logic            eq, lt_s, lt_u;
    logic [IDXW-1:0] upd_idx;
    logic [IDXW-1:0] lk_idx;
    logic            unused_pc;

    assign upd_idx   = pc_q[IDXW+1:2];
    assign lk_idx    = pred_pc[IDXW+1:2];
    assign unused_pc = ^{pred_pc[31:IDXW+2], pred_pc[1:0]};

    assign eq   = (op_a == op_b);
    assign lt_s = ($signed(op_a) < $signed(op_b));
    assign lt_u = (op_a < op_b);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (type_q)
            3'b000:  taken = eq;
            3'b001:  taken = !eq;
            3'b100:  taken = lt_s;
            3'b101:  taken = !lt_s;
            3'b110:  taken = lt_u;
            3'b111:  taken = !lt_u;
            default: legal = 1'b0;
        endcase
    end

    assign mispred = (taken != pred_q);
    assign accept  = (state_q == IDLE) && req_valid && !kill;
    // kill outranks operand arrival: an aborted branch never updates BHT or stats
    assign resolve = (state_q == EVAL) && ops_valid && !kill;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EVAL;
            EVAL: begin
                if (kill) begin
                    state_d = IDLE;
                end else if (ops_valid) begin
                    state_d = mispred ? REDIR : IDLE;
                end
            end
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rpc_d = rpc_q;
        if (resolve) begin
            rpc_d = taken ? (pc_q + imm_q) : (pc_q + 32'd4);
        end
    end

    always_comb begin
        bht_d = bht_q[upd_idx];
        if (taken) begin
            if (bht_d != 2'b11) bht_d = bht_d + 2'b01;
        end else begin
            if (bht_d != 2'b00) bht_d = bht_d - 2'b01;
        end
    end

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (resolve && legal) begin
            if (!(&br_cnt_q)) br_cnt_d = br_cnt_q + CNTW'(1);
            if (mispred && !(&mis_cnt_q)) mis_cnt_d = mis_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            type_q    <= 3'b000;
            pc_q      <= 32'd0;
            imm_q     <= 32'd0;
            pred_q    <= 1'b0;
            rpc_q     <= 32'd0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rpc_q     <= rpc_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
            if (accept) begin
                type_q <= req_type;
                pc_q   <= req_pc;
                imm_q  <= req_imm;
                pred_q <= req_pred;
            end
        end
    end

    // Reset every entry to weakly not-taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BhtN; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (resolve && legal) begin
            bht_q[upd_idx] <= bht_d;
        end
    end

    // Registered-array read: a same-cycle update is not visible until the next cycle
    assign pred_taken     = bht_q[lk_idx][1];
    assign req_ready      = (state_q == IDLE) && !kill;
    assign redirect_valid = (state_q == REDIR) && !kill;
    assign flush          = redirect_valid;
    assign redirect_pc    = rpc_q;
    assign stat_branches  = br_cnt_q;
    assign stat_mispred   = mis_cnt_q;

endmodule

// File: tb/tb_br_ctrl.sv
// Bench for br_ctrl: transaction-level reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_br_ctrl;

    localparam int CNTW = 4;
    localparam int MAXC = (1 << CNTW) - 1;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_type;
    logic [31:0]     req_pc;
    logic [31:0]     req_imm;
    logic            req_pred;
    logic            ops_valid;
    logic [31:0]     op_a;
    logic [31:0]     op_b;
    logic            kill;
    logic [31:0]     pred_pc;
    logic            pred_taken;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            flush;
    logic [CNTW-1:0] stat_branches;
    logic [CNTW-1:0] stat_mispred;

    br_ctrl #(
        .DATAW(32),
        .IDXW (6),
        .CNTW (CNTW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_type      (req_type),
        .req_pc        (req_pc),
        .req_imm       (req_imm),
        .req_pred      (req_pred),
        .ops_valid     (ops_valid),
        .op_a          (op_a),
        .op_b          (op_b),
        .kill          (kill),
        .pred_pc       (pred_pc),
        .pred_taken    (pred_taken),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules for branch outcome
    function automatic bit f_taken(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
        case (t)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit f_legal(input logic [2:0] t);
        return (t != 3'b010) && (t != 3'b011);
    endfunction

    function automatic int f_sat2(input int v, input bit up);
        if (up) return (v == 3) ? 3 : v + 1;
        return (v == 0) ? 0 : v - 1;
    endfunction

    function automatic int f_inc(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    // Model: phase 0 waiting for a branch, 1 waiting for operands, 2 redirecting
    int          m_phase;
    int          m_br;
    int          m_mis;
    int          m_bht [64];
    logic [31:0] m_rpc;
    logic [2:0]  l_type;
    logic [31:0] l_pc;
    logic [31:0] l_imm;
    logic        l_pred;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_br    <= 0;
            m_mis   <= 0;
            m_rpc   <= 32'd0;
            for (int i = 0; i < 64; i++) m_bht[i] <= 1;
        end else if (m_phase == 0) begin
            if (req_valid && !kill) begin
                l_type  <= req_type;
                l_pc    <= req_pc;
                l_imm   <= req_imm;
                l_pred  <= req_pred;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            if (kill) begin
                m_phase <= 0;
            end else if (ops_valid) begin
                m_rpc <= f_taken(l_type, op_a, op_b) ? l_pc + l_imm : l_pc + 32'd4;
                if (f_legal(l_type)) begin
                    m_bht[int'(l_pc[7:2])] <= f_sat2(m_bht[int'(l_pc[7:2])],
                                                     f_taken(l_type, op_a, op_b));
                    m_br <= f_inc(m_br);
                    if (f_taken(l_type, op_a, op_b) != l_pred) m_mis <= f_inc(m_mis);
                end
                m_phase <= (f_taken(l_type, op_a, op_b) != l_pred) ? 2 : 0;
            end
        end else begin
            m_phase <= 0;
        end
    end

    bit exp_rv;
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_rv = (m_phase == 2) && !kill;
                check("req_ready", {31'd0, req_ready}, {31'd0, (m_phase == 0) && !kill});
                check("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_rv});
                check("flush", {31'd0, flush}, {31'd0, exp_rv});
                if (exp_rv) check("redirect_pc", redirect_pc, m_rpc);
                check("pred_taken", {31'd0, pred_taken},
                      {31'd0, m_bht[int'(pred_pc[7:2])] >= 2});
                check("stat_branches", 32'(stat_branches), 32'(m_br));
                check("stat_mispred", 32'(stat_mispred), 32'(m_mis));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] t, input logic [31:0] pc, input logic [31:0] imm,
                         input logic p);
        req_valid = 1'b1;
        req_type  = t;
        req_pc    = pc;
        req_imm   = imm;
        req_pred  = p;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] a, input logic [31:0] b);
        ops_valid = 1'b1;
        op_a      = a;
        op_b      = b;
        tick();
        ops_valid = 1'b0;
    endtask

    task automatic branch(input logic [2:0] t, input logic [31:0] pc, input logic [31:0] imm,
                          input logic p, input logic [31:0] a, input logic [31:0] b);
        issue(t, pc, imm, p);
        resolve(a, b);
        if (f_taken(t, a, b) != p) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_type  = 3'b000;
        req_pc    = 32'd0;
        req_imm   = 32'd0;
        req_pred  = 1'b0;
        ops_valid = 1'b0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        kill      = 1'b0;
        pred_pc   = 32'd0;
        #1 rst = 1'b1;
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_branches", 32'(stat_branches), 32'd0);
        check("rst_pred", {31'd0, pred_taken}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // BEQ equal, predicted not-taken: mispredict to 0x120
        issue(3'b000, 32'h100, 32'h20, 1'b0);
        #1 check("t1_ready_eval", {31'd0, req_ready}, 32'd0);
        resolve(32'd5, 32'd5);
        #1;
        check("t1_redirect", {31'd0, redirect_valid}, 32'd1);
        check("t1_rpc", redirect_pc, 32'h120);
        check("t1_flush", {31'd0, flush}, 32'd1);
        check("t1_mispred", 32'(stat_mispred), 32'd1);
        check("t1_branches", 32'(stat_branches), 32'd1);
        tick();
        #1;
        check("t1_redirect_off", {31'd0, redirect_valid}, 32'd0);
        check("t1_ready_back", {31'd0, req_ready}, 32'd1);
        pred_pc = 32'h100;
        #1 check("t1_bht_10", {31'd0, pred_taken}, 32'd1);

        // BLT signed taken, then BLTU same operands not taken
        issue(3'b100, 32'h200, 32'h10, 1'b1);
        resolve(32'hFFFF_FFFF, 32'd1);
        #1;
        check("t2_blt_noredir", {31'd0, redirect_valid}, 32'd0);
        check("t2_blt_ready", {31'd0, req_ready}, 32'd1);
        issue(3'b110, 32'h200, 32'h10, 1'b1);
        resolve(32'hFFFF_FFFF, 32'd1);
        #1;
        check("t2_bltu_redir", {31'd0, redirect_valid}, 32'd1);
        check("t2_bltu_rpc", redirect_pc, 32'h204);
        tick();

        // Operands late by 5 cycles
        issue(3'b001, 32'h300, 32'h40, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1 check("t3_wait_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        resolve(32'd1, 32'd2);
        #1 check("t3_resolved", {31'd0, req_ready}, 32'd1);

        // BHT training at 0x40 with same-cycle lookup
        pred_pc = 32'h40;
        issue(3'b000, 32'h40, 32'h8, 1'b1);
        ops_valid = 1'b1;
        op_a      = 32'd7;
        op_b      = 32'd7;
        #1 check("t4_same_cycle_old", {31'd0, pred_taken}, 32'd0);
        tick();
        ops_valid = 1'b0;
        #1 check("t4_after_one", {31'd0, pred_taken}, 32'd1);
        branch(3'b000, 32'h40, 32'h8, 1'b1, 32'd7, 32'd7);
        branch(3'b000, 32'h40, 32'h8, 1'b1, 32'd7, 32'd7);
        #1 check("t4_sat", {31'd0, pred_taken}, 32'd1);
        branch(3'b001, 32'h40, 32'h8, 1'b1, 32'd7, 32'd7);
        #1 check("t4_sat_dec", {31'd0, pred_taken}, 32'd1);

        branch(3'b101, 32'h900, 32'h4, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFB);
        branch(3'b111, 32'h904, 32'h4, 1'b0, 32'd1, 32'hFFFF_FFFF);
        branch(3'b000, 32'h908, 32'h4, 1'b1, 32'h10, 32'h11);
        branch(3'b100, 32'h90C, 32'h4, 1'b0, 32'd1, 32'hFFFF_FFFF);

        // kill in EVAL
        issue(3'b000, 32'h500, 32'h10, 1'b0);
        kill      = 1'b1;
        ops_valid = 1'b1;
        op_a      = 32'd3;
        op_b      = 32'd3;
        #1 check("t5_kill_eval_rdy", {31'd0, req_ready}, 32'd0);
        tick();
        kill      = 1'b0;
        ops_valid = 1'b0;
        #1;
        check("t5_kill_noredir", {31'd0, redirect_valid}, 32'd0);
        check("t5_kill_ready", {31'd0, req_ready}, 32'd1);
        check("t5_kill_br", 32'(stat_branches), 32'd12);
        check("t5_kill_mis", 32'(stat_mispred), 32'd4);

        // kill in REDIR
        issue(3'b000, 32'h600, 32'h10, 1'b0);
        resolve(32'd3, 32'd3);
        kill = 1'b1;
        #1;
        check("t5_kredir_rv", {31'd0, redirect_valid}, 32'd0);
        check("t5_kredir_flush", {31'd0, flush}, 32'd0);
        tick();
        kill = 1'b0;
        #1;
        check("t5_kredir_ready", {31'd0, req_ready}, 32'd1);
        check("t5_kredir_br", 32'(stat_branches), 32'd13);
        check("t5_kredir_mis", 32'(stat_mispred), 32'd5);

        // kill in IDLE blocks acceptance
        kill      = 1'b1;
        req_valid = 1'b1;
        req_type  = 3'b000;
        req_pc    = 32'h700;
        #1 check("t5_kidle_ready", {31'd0, req_ready}, 32'd0);
        tick();
        kill      = 1'b0;
        req_valid = 1'b0;
        #1 check("t5_kidle_noacc", {31'd0, req_ready}, 32'd1);

        // async reset mid-EVAL
        pred_pc = 32'h40;
        issue(3'b000, 32'h40, 32'h8, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_ready", {31'd0, req_ready}, 32'd1);
        check("t5_rst_br", 32'(stat_branches), 32'd0);
        check("t5_rst_bht", {31'd0, pred_taken}, 32'd0);
        #4 rst = 1'b0;
        tick();

        // illegal type 010 predicted taken
        issue(3'b010, 32'h700, 32'h30, 1'b1);
        resolve(32'd1, 32'd1);
        #1;
        check("t6_ill_redir", {31'd0, redirect_valid}, 32'd1);
        check("t6_ill_rpc", redirect_pc, 32'h704);
        check("t6_ill_br", 32'(stat_branches), 32'd0);
        tick();
        pred_pc = 32'h700;
        #1 check("t6_ill_bht", {31'd0, pred_taken}, 32'd0);

        // counter saturation
        for (int i = 0; i < 20; i++) branch(3'b000, 32'h800, 32'h4, 1'b0, 32'd9, 32'd9);
        #1;
        check("t6_sat_br", 32'(stat_branches), 32'd15);
        check("t6_sat_mis", 32'(stat_mispred), 32'd15);
        branch(3'b000, 32'h800, 32'h4, 1'b1, 32'd9, 32'd9);
        #1 check("t6_sat_hold", 32'(stat_branches), 32'd15);

        repeat (3) tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/br_ctrl.md
Name: br_ctrl

Overview:
- Branch resolution controller for the execute stage of the RV core.
- Accepts one conditional branch at a time through a valid/ready handshake and waits for forwarded operands.
- Evaluates the branch condition using the core's 3-bit branch-type encoding, checks the outcome against fetch's prediction, and issues a one-cycle redirect/flush on mispredict.
- Owns a 2-bit saturating branch history table (BHT) read by fetch, plus branch and mispredict statistics counters.

Parameters:
- DATAW, 32, operand width
- IDXW, 6, BHT index width (2^IDXW entries)
- CNTW, 32, statistics counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  branch issue valid
- req_ready  out  1  controller can accept a branch
- req_type  in  3  funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU
- req_pc  in  32  branch PC
- req_imm  in  32  sign-extended branch offset
- req_pred  in  1  fetch predicted taken
- ops_valid  in  1  op_a/op_b hold final forwarded values this cycle
- op_a  in  DATAW  rs1 value
- op_b  in  DATAW  rs2 value
- kill  in  1  older-instruction flush; aborts the pending branch
- pred_pc  in  32  fetch lookup PC
- pred_taken  out  1  BHT prediction for pred_pc
- redirect_valid  out  1  redirect fetch this cycle
- redirect_pc  out  32  corrected PC
- flush  out  1  squash younger instructions in IF/ID
- stat_branches  out  CNTW  resolved valid branches
- stat_mispred  out  CNTW  mispredicted branches

Behaviour:
- Clock/reset: one clock (clk); reset asynchronous, active-high (rst).
- Reset values: state=IDLE, req_ready=1, redirect_valid=0, flush=0, redirect_pc=0, both stat counters=0, every BHT entry=2'b01 (weakly not-taken). Reset mid-operation drops any pending branch with no redirect and no BHT/stat update.
- FSM states: IDLE, EVAL, REDIR.
  - IDLE: req_ready=1. On req_valid: latch type, pc, imm, pred; go to EVAL.
  - EVAL: req_ready=0. Operands sampled only when ops_valid=1; if ops_valid=0, stay in EVAL indefinitely.
  - EVAL with ops_valid=1: compute taken; update BHT and stats. If taken!=pred go to REDIR, else go to IDLE.
  - REDIR: redirect_valid=1 and flush=1 for exactly one cycle; req_ready=0; next state IDLE.
- Condition evaluation:
  - EQ/NE compare op_a and op_b as bits; LT/GE compare signed; LTU/GEU compare unsigned.
  - Types 010/011 are illegal: taken=0, no BHT update, no stat increment; a redirect still occurs if pred=1.
- redirect_pc: taken ? pc+imm : pc+4, modulo 2^32, computed from latched values.
- Latency: accepted at cycle T; earliest resolution at T+1; redirect asserted at T+2. Minimum spacing between accepts is 2 cycles (correct prediction) or 3 cycles (mispredict).
- kill has priority in every state:
  - EVAL: go to IDLE with no update.
  - REDIR: redirect_valid and flush forced to 0 combinationally; go to IDLE.
  - IDLE: req_ready forced to 0 and no accept.
- BHT:
  - Index = pc[IDXW+1:2].
  - Update on resolve: +1 if taken, -1 if not taken, saturating at 00 and 11.
  - pred_taken = bit 1 of entry[pred_pc index], combinational read.
  - A lookup and an update to the same index in the same cycle return the pre-update value (no bypass).
- Stats:
  - stat_branches increments on each legal resolution.
  - stat_mispred increments when a legal resolution has taken!=pred.
  - Both saturate at all-ones and never wrap.

Test Plan:
- Reset, then BEQ pc=0x100 imm=0x20 a=b=5 pred=0, ops_valid=1 -> resolved T+1; redirect at T+2 with redirect_pc=0x120, flush=1 for 1 cycle; stat_mispred=1; BHT[0x100] 01->10.
- BLT a=0xFFFFFFFF b=1 pred=1 -> taken, no redirect, req_ready back at T+2. Then BLTU with the same operands and pred=1 -> not taken; redirect_pc=pc+4.
- ops_valid low for 5 cycles after accept -> stays in EVAL with req_ready=0; resolves on the first cycle ops_valid=1.
- Three taken branches at pc=0x40, then lookup pred_pc=0x40 -> pred_taken=1, counter saturated at 11. Same-cycle lookup and update at 0x40 returns the old value.
- kill asserted in EVAL -> no redirect, stats unchanged. kill in REDIR -> redirect_valid=0. Async rst pulse mid-EVAL -> immediate IDLE, BHT entries=01.
- Illegal type 010 with pred=1 -> redirect to pc+4; stat_branches unchanged. Preload counters to all-ones -> they stay saturated.
